// File: rtl/issue_scoreboard_pkg.sv
// Shared constants and FSM state type for the decode-stage issue scoreboard.
package issue_scoreboard_pkg;

    localparam int SB_RF_NUM = 32;
    localparam int SB_CNT_W  = 2;

    typedef enum logic {
        SB_RUN   = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_e;

endpackage

// File: rtl/issue_scoreboard_sb_cnt_cell.sv
// One saturating pending-write counter for a single architectural register.
// SB_WB_BYPASS_EN: hazard view ignores a last pending write retiring this cycle.
module sb_cnt_cell #(
    parameter int CNT_W = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic busy,
    output logic full,
    output logic underflow,
    output logic haz_busy
);

    logic [CNT_W-1:0] cnt;

    assign busy      = |cnt;
    assign full      = &cnt;
    assign underflow = dec & ~busy;

`ifdef SB_WB_BYPASS_EN
    // Regfile write-through supplies the value when the only pending write retires now.
    assign haz_busy = busy & ~(dec & (cnt == CNT_W'(1)));
`else
    assign haz_busy = busy;
`endif

    // Simultaneous inc and dec cancel; dec at zero holds rather than wrapping.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && busy) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-stage issue controller: RAW/full stall from per-register pending counters, flush drain FSM.
// SB_WB_BYPASS_EN lets a dependent issue in the writeback cycle of its last pending producer.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int RF_NUM = SB_RF_NUM,
    parameter int CNT_W  = SB_CNT_W,
    parameter int IDX_W  = $clog2(RF_NUM)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_stop,
    input  logic              i_flush,
    input  logic              i_pipe_empty,
    input  logic              i_inst_vld,
    input  logic              i_rs1ren,
    input  logic [IDX_W-1:0]  i_rs1idx,
    input  logic              i_rs2ren,
    input  logic [IDX_W-1:0]  i_rs2idx,
    input  logic              i_rdwen,
    input  logic [IDX_W-1:0]  i_rdidx,
    input  logic              i_wb_rdwen,
    input  logic [IDX_W-1:0]  i_wb_rdidx,
    output logic              o_stall,
    output logic              o_issue,
    output logic              o_draining,
    output logic [RF_NUM-1:0] o_busy_vec,
    output logic              o_sb_err,
    output sb_state_e         o_state
);

    sb_state_e         state_q, state_d;
    logic              clr_all;
    logic [RF_NUM-1:0] full_vec, haz_vec, unf_vec;
    logic              haz1, haz2, full_hit, issue_wr;

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state_q <= SB_RUN;
        else         state_q <= state_d;
    end

    // A flush in DRAIN restarts the wait; counters clear only on the DRAIN->RUN edge.
    always_comb begin
        state_d = state_q;
        clr_all = 1'b0;
        case (state_q)
            SB_RUN: begin
                if (i_flush) state_d = SB_DRAIN;
            end
            SB_DRAIN: begin
                if (!i_flush && i_pipe_empty) begin
                    state_d = SB_RUN;
                    clr_all = 1'b1;
                end
            end
            default: state_d = SB_RUN;
        endcase
    end

    assign haz1     = i_rs1ren & (|i_rs1idx) & haz_vec[i_rs1idx];
    assign haz2     = i_rs2ren & (|i_rs2idx) & haz_vec[i_rs2idx];
    assign full_hit = i_rdwen  & (|i_rdidx)  & full_vec[i_rdidx];

    assign o_draining = (state_q == SB_DRAIN);
    assign o_stall    = i_inst_vld & (o_draining | i_flush | haz1 | haz2 | full_hit);
    assign o_issue    = i_inst_vld & ~o_stall & ~i_stop;
    assign issue_wr   = o_issue & i_rdwen & (|i_rdidx);
    assign o_state    = state_q;

    assign o_busy_vec[0] = 1'b0;
    assign full_vec[0]   = 1'b0;
    assign haz_vec[0]    = 1'b0;
    assign unf_vec[0]    = 1'b0;

    // x0 is never tracked, so cells start at x1.
    for (genvar g = 1; g < RF_NUM; g++) begin : g_cell
        logic inc_g, dec_g;
        assign inc_g = issue_wr & (i_rdidx == IDX_W'(g));
        assign dec_g = i_wb_rdwen & (i_wb_rdidx == IDX_W'(g));

        sb_cnt_cell #(.CNT_W(CNT_W)) u_cell (
            .i_clk     (i_clk),
            .i_rstn    (i_rstn),
            .inc       (inc_g),
            .dec       (dec_g),
            .clr       (clr_all),
            .busy      (o_busy_vec[g]),
            .full      (full_vec[g]),
            .underflow (unf_vec[g]),
            .haz_busy  (haz_vec[g])
        );
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) o_sb_err <= 1'b0;
        else         o_sb_err <= o_sb_err | (|unf_vec);
    end

endmodule
